// File: rtl/spike_out_packer.sv
`default_nettype none
// ============================================================================
// Module      : spike_out_packer
// Description : Gathers per-neuron spike results for one timestep into a
//               32-bit vector and issues a one-cycle write of that vector to
//               neuron_spike_out once every neuron has reported. Counts
//               completed frames and flags duplicate or out-of-range results.
// Revision    : 1.0 - initial release
// ============================================================================
module spike_out_packer #(
    parameter int NUM_NEURONS = 32,
    parameter int IDX_W       = 5,
    parameter int FCNT_W      = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              spike_valid_i,
    input  logic              spike_i,
    input  logic [IDX_W-1:0]  neuron_idx_i,
    output logic              ready_o,
    output logic              busy_o,
    output logic [31:0]       external_spike_data_o,
    output logic              external_write_en_o,
    output logic [FCNT_W-1:0] frame_count_o,
    output logic              err_o
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_FLUSH   = 2'd2;

    // Counter must be able to hold the value 32 itself.
    localparam int          c_CNT_W      = 6;
    localparam logic [31:0] c_VALID_MASK = (NUM_NEURONS >= 32) ? 32'hFFFF_FFFF
                                         : 32'((33'd1 << NUM_NEURONS) - 33'd1);

    logic [1:0]         r_state;
    logic [31:0]        r_shadow;
    logic [31:0]        r_seen;
    logic [c_CNT_W-1:0] r_cnt;
    logic [31:0]        r_data;
    logic               r_we;
    logic [FCNT_W-1:0]  r_fcnt;
    logic               r_err;

    logic [31:0]        w_onehot;
    logic               w_in_range;
    logic               w_dup;
    logic               w_accept;
    logic               w_last;
    logic [31:0]        w_shadow_next;

    // Decode the incoming result: its bit position, legality and whether it closes the frame.
    always_comb begin
        w_onehot      = 32'd1 << neuron_idx_i;
        w_in_range    = 32'(neuron_idx_i) < NUM_NEURONS;
        w_dup         = |(r_seen & w_onehot);
        // Abort has priority, so a result arriving alongside it is dropped.
        w_accept      = spike_valid_i && (r_state == S_COLLECT) && !abort_i;
        w_shadow_next = spike_i ? (r_shadow | w_onehot) : (r_shadow & ~w_onehot);
        w_last        = (r_cnt + c_CNT_W'(1)) == c_CNT_W'(NUM_NEURONS);
    end

    // Frame state machine, collection datapath, output strobe and frame counter.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state  <= S_IDLE;
            r_shadow <= 32'd0;
            r_seen   <= 32'd0;
            r_cnt    <= '0;
            r_data   <= 32'd0;
            r_we     <= 1'b0;
            r_fcnt   <= '0;
            r_err    <= 1'b0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_shadow <= 32'd0;
                        r_seen   <= 32'd0;
                        r_cnt    <= '0;
                        r_state  <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (abort_i) begin
                        r_state <= S_IDLE;
                    end else if (w_accept) begin
                        if (!w_in_range || w_dup) begin
                            r_err <= 1'b1;
                        end else begin
                            r_shadow <= w_shadow_next;
                            r_seen   <= r_seen | w_onehot;
                            r_cnt    <= r_cnt + c_CNT_W'(1);
                            if (w_last) begin
                                r_data  <= w_shadow_next & c_VALID_MASK;
                                r_we    <= 1'b1;
                                r_state <= S_FLUSH;
                            end
                        end
                    end
                end
                S_FLUSH: begin
                    r_fcnt  <= r_fcnt + FCNT_W'(1);
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ready_o               = (r_state == S_COLLECT);
    assign busy_o                = (r_state == S_COLLECT) || (r_state == S_FLUSH);
    assign external_spike_data_o = r_data;
    assign external_write_en_o   = r_we;
    assign frame_count_o         = r_fcnt;
    assign err_o                 = r_err;

endmodule
`default_nettype wire
